// File: rtl/ex2_mem_access_unit.sv
// rtl/ex2_mem_access_unit.sv - EX2 load/store to single-outstanding valid/ready bus transaction
// Holds the pipeline while a request is in flight and returns extended load data or exceptions.
module ex2_mem_access_unit #(
   parameter int XLEN        = 64,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            cancel_instr_ex2,
   input  logic            rdata_en_ex2,
   input  logic            wdata_en_ex2,
   input  logic [1:0]      rlen_ex2,
   input  logic [1:0]      wlen_ex2,
   input  logic            load_unsigned,
   input  logic [XLEN-1:0] mem_addr_ex2,
   input  logic [XLEN-1:0] wdata_ex2,
   input  logic [4:0]      rd_ex2,
   output logic            mem_hold,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic [XLEN-1:0] bus_req_addr,
   output logic            bus_req_we,
   output logic [7:0]      bus_req_wstrb,
   output logic [XLEN-1:0] bus_req_wdata,
   input  logic            bus_resp_valid,
   input  logic [XLEN-1:0] bus_resp_rdata,
   input  logic            bus_resp_err,
   output logic            load_data_valid,
   output logic [XLEN-1:0] load_data,
   output logic [4:0]      load_rd,
   output logic            misalign_exc,
   output logic            access_fault_exc
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]      r_state;
   logic            r_we;
   logic            r_unsigned;
   logic            r_discard;
   logic [1:0]      r_size;
   logic [2:0]      r_off;
   logic [4:0]      r_rd;
   logic [TW-1:0]   r_tcnt;

   logic            w_go;
   logic            w_store;
   logic [1:0]      w_size;
   logic [2:0]      w_off;
   logic            w_misaligned;
   logic [7:0]      w_mask;
   logic            w_aligned_go;
   logic            w_kill;
   logic            w_timeout;
   logic            w_resp_err;
   logic            w_discard;
   logic [XLEN-1:0] w_raw;
   logic [XLEN-1:0] w_ext;

   assign w_go         = (rdata_en_ex2 | wdata_en_ex2) & ~cancel_instr_ex2 & ~flush;
   assign w_store      = wdata_en_ex2;
   assign w_size       = w_store ? wlen_ex2 : rlen_ex2;
   assign w_off        = mem_addr_ex2[2:0];
   assign w_aligned_go = (r_state == S_IDLE) & w_go & ~w_misaligned;
   assign w_kill       = flush | cancel_instr_ex2;
   assign w_timeout    = (r_tcnt == TW'(TIMEOUT_CYC - 1));
   assign w_resp_err   = bus_resp_valid ? bus_resp_err : 1'b1;
   assign w_discard    = r_discard | w_kill;

   assign mem_hold      = w_aligned_go | (r_state == S_REQ) | (r_state == S_RESP);
   assign bus_req_valid = (r_state == S_REQ);

   always_comb begin
      w_misaligned = 1'b0;
      w_mask       = 8'h01;
      case (w_size)
         2'd0: begin w_misaligned = 1'b0;               w_mask = 8'h01; end
         2'd1: begin w_misaligned = w_off[0];           w_mask = 8'h03; end
         2'd2: begin w_misaligned = |w_off[1:0];        w_mask = 8'h0F; end
         default: begin w_misaligned = |w_off;          w_mask = 8'hFF; end
      endcase
   end

   // Sign bit comes from the top of the loaded width, not from the full bus word.
   assign w_raw = bus_resp_rdata >> {r_off, 3'b000};
   always_comb begin
      w_ext = w_raw;
      case (r_size)
         2'd0: w_ext = {{(XLEN-8){~r_unsigned & w_raw[7]}}, w_raw[7:0]};
         2'd1: w_ext = {{(XLEN-16){~r_unsigned & w_raw[15]}}, w_raw[15:0]};
         2'd2: w_ext = {{(XLEN-32){~r_unsigned & w_raw[31]}}, w_raw[31:0]};
         default: w_ext = w_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state          <= S_IDLE;
         r_we             <= 1'b0;
         r_unsigned       <= 1'b0;
         r_discard        <= 1'b0;
         r_size           <= 2'd0;
         r_off            <= 3'd0;
         r_rd             <= 5'd0;
         r_tcnt           <= '0;
         bus_req_addr     <= '0;
         bus_req_we       <= 1'b0;
         bus_req_wstrb    <= 8'h00;
         bus_req_wdata    <= '0;
         load_data_valid  <= 1'b0;
         load_data        <= '0;
         load_rd          <= 5'd0;
         misalign_exc     <= 1'b0;
         access_fault_exc <= 1'b0;
      end else begin
         misalign_exc     <= 1'b0;
         load_data_valid  <= 1'b0;
         access_fault_exc <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  if (w_misaligned) begin
                     misalign_exc <= 1'b1;
                  end else begin
                     r_state       <= S_REQ;
                     r_we          <= w_store;
                     r_unsigned    <= load_unsigned;
                     r_discard     <= 1'b0;
                     r_size        <= w_size;
                     r_off         <= w_off;
                     r_rd          <= rd_ex2;
                     bus_req_addr  <= {mem_addr_ex2[XLEN-1:3], 3'b000};
                     bus_req_we    <= w_store;
                     bus_req_wstrb <= w_store ? (w_mask << w_off) : 8'h00;
                     bus_req_wdata <= w_store ? (wdata_ex2 << {w_off, 3'b000}) : '0;
                  end
               end
            end
            S_REQ: begin
               if (w_kill) r_discard <= 1'b1;
               if (bus_req_ready) begin
                  r_state <= S_RESP;
                  r_tcnt  <= '0;
               end
            end
            S_RESP: begin
               if (w_kill) r_discard <= 1'b1;
               if (bus_resp_valid || w_timeout) begin
                  r_state <= S_DONE;
                  if (!w_discard) begin
                     if (w_resp_err) begin
                        access_fault_exc <= 1'b1;
                     end else if (!r_we) begin
                        load_data_valid <= 1'b1;
                        load_data       <= w_ext;
                        load_rd         <= r_rd;
                     end
                  end
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex2_mem_access_unit.sv
// tb/tb_ex2_mem_access_unit.sv - directed and randomized bench for ex2_mem_access_unit
module tb_ex2_mem_access_unit;
   localparam int TMO = 256;

   logic        clk = 1'b0;
   logic        rstn, flush, cancel_instr_ex2, rdata_en_ex2, wdata_en_ex2;
   logic [1:0]  rlen_ex2, wlen_ex2;
   logic        load_unsigned;
   logic [63:0] mem_addr_ex2, wdata_ex2;
   logic [4:0]  rd_ex2;
   logic        mem_hold, bus_req_valid, bus_req_ready, bus_req_we;
   logic [63:0] bus_req_addr, bus_req_wdata;
   logic [7:0]  bus_req_wstrb;
   logic        bus_resp_valid, bus_resp_err;
   logic [63:0] bus_resp_rdata;
   logic        load_data_valid;
   logic [63:0] load_data;
   logic [4:0]  load_rd;
   logic        misalign_exc, access_fault_exc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ex2_mem_access_unit #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .cancel_instr_ex2(cancel_instr_ex2),
      .rdata_en_ex2(rdata_en_ex2), .wdata_en_ex2(wdata_en_ex2),
      .rlen_ex2(rlen_ex2), .wlen_ex2(wlen_ex2), .load_unsigned(load_unsigned),
      .mem_addr_ex2(mem_addr_ex2), .wdata_ex2(wdata_ex2), .rd_ex2(rd_ex2),
      .mem_hold(mem_hold), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we), .bus_req_wstrb(bus_req_wstrb),
      .bus_req_wdata(bus_req_wdata), .bus_resp_valid(bus_resp_valid),
      .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err),
      .load_data_valid(load_data_valid), .load_data(load_data), .load_rd(load_rd),
      .misalign_exc(misalign_exc), .access_fault_exc(access_fault_exc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [63:0] a);
      return (a % (64'd1 << sz)) != 64'd0;
   endfunction

   function automatic logic [7:0] m_wstrb(input logic [1:0] sz, input logic [63:0] a);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < (1 << sz); i++) s[int'(a[2:0]) + i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [63:0] a,
                                          input logic [1:0] sz, input bit uns);
      int nb = 1 << sz;
      int off = int'(a[2:0]);
      logic [63:0] v = 64'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
      if (!uns && nb < 8 && v[8*nb-1])
         for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   task automatic do_access(input bit st, input logic [1:0] sz, input logic [63:0] a,
                            input logic [63:0] wd, input bit uns, input logic [4:0] rd,
                            input int rdy_dly, input int resp_dly, input logic [63:0] rdat,
                            input bit err, input bit fl);
      bit mis, tmo, exp_fault, exp_ldv;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wd;
      mis      = m_misaligned(sz, a);
      tmo      = (resp_dly >= TMO);
      exp_strb = st ? m_wstrb(sz, a) : 8'h00;
      exp_wd   = st ? (wd << (8 * a[2:0])) : 64'h0;
      exp_fault = !fl && (err || tmo);
      exp_ldv   = !fl && !st && !(err || tmo);

      wdata_en_ex2  = st;
      rdata_en_ex2  = st ? 1'($urandom % 2) : 1'b1;
      rlen_ex2      = st ? 2'($urandom % 4) : sz;
      wlen_ex2      = sz;
      load_unsigned = uns;
      mem_addr_ex2  = a;
      wdata_ex2     = wd;
      rd_ex2        = rd;
      #1 chk("hold_idle", mem_hold, !mis);
      @(negedge clk);
      rdata_en_ex2 = 1'b0;
      wdata_en_ex2 = 1'b0;
      #1;
      if (mis) begin
         chk("misalign_pulse", misalign_exc, 1);
         chk("misalign_hold", mem_hold, 0);
         chk("misalign_valid", bus_req_valid, 0);
         @(negedge clk); #1;
         chk("misalign_end", misalign_exc, 0);
         return;
      end
      for (int k = 0; k <= rdy_dly; k++) begin
         bus_req_ready = (k == rdy_dly);
         #1;
         chk("req_valid", bus_req_valid, 1);
         chk("req_hold", mem_hold, 1);
         chk("req_addr", bus_req_addr, {a[63:3], 3'b000});
         chk("req_we", bus_req_we, st);
         chk("req_wstrb", bus_req_wstrb, exp_strb);
         chk("req_wdata", bus_req_wdata, exp_wd);
         @(negedge clk);
      end
      bus_req_ready = 1'b0;
      for (int k = 0; k < resp_dly && k < TMO; k++) begin
         flush = 1'b0;
         cancel_instr_ex2 = 1'b0;
         if (fl && k == 0) begin
            if ($urandom % 2 == 0) flush = 1'b1;
            else cancel_instr_ex2 = 1'b1;
         end
         #1;
         chk("resp_hold", mem_hold, 1);
         chk("resp_valid_low", bus_req_valid, 0);
         @(negedge clk);
      end
      flush = 1'b0;
      cancel_instr_ex2 = 1'b0;
      if (!tmo) begin
         bus_resp_valid = 1'b1;
         bus_resp_rdata = rdat;
         bus_resp_err   = err;
         #1 chk("resp_hold_last", mem_hold, 1);
         @(negedge clk);
         bus_resp_valid = 1'b0;
         bus_resp_err   = 1'b0;
      end
      #1;
      chk("done_hold", mem_hold, 0);
      chk("done_fault", access_fault_exc, exp_fault);
      chk("done_ldv", load_data_valid, exp_ldv);
      if (exp_ldv) begin
         chk("done_data", load_data, m_load(rdat, a, sz, uns));
         chk("done_rd", {59'h0, load_rd}, {59'h0, rd});
      end
      @(negedge clk); #1;
      chk("after_ldv", load_data_valid, 0);
      chk("after_fault", access_fault_exc, 0);
      chk("after_hold", mem_hold, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b1; flush = 1'b0; cancel_instr_ex2 = 1'b0;
      rdata_en_ex2 = 1'b0; wdata_en_ex2 = 1'b0; rlen_ex2 = 2'd0; wlen_ex2 = 2'd0;
      load_unsigned = 1'b0; mem_addr_ex2 = 64'h0; wdata_ex2 = 64'h0; rd_ex2 = 5'd0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = 64'h0; bus_resp_err = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", bus_req_valid, 0);
      chk("rst_hold", mem_hold, 0);
      chk("rst_addr", bus_req_addr, 0);
      chk("rst_ldata", load_data, 0);
      chk("rst_misalign", misalign_exc, 0);
      rstn = 1'b0;
      @(negedge clk);

      do_access(0, 2'd0, 64'h1003, 64'h0, 0, 5'd7, 0, 1, 64'h0000_0000_8000_0000, 0, 0);
      chk("lb_const", load_data, 64'hFFFF_FFFF_FFFF_FF80);
      do_access(0, 2'd0, 64'h1003, 64'h0, 1, 5'd8, 0, 1, 64'h0000_0000_8000_0000, 0, 0);
      chk("lbu_const", load_data, 64'h80);
      do_access(1, 2'd1, 64'h2006, 64'hBEEF, 0, 5'd0, 1, 0, 64'h0, 0, 0);
      do_access(0, 2'd2, 64'h1002, 64'h0, 0, 5'd9, 0, 0, 64'h0, 0, 0);
      do_access(0, 2'd3, 64'h4000, 64'h0, 0, 5'd10, 5, 0, 64'h1234, 1, 0);
      do_access(0, 2'd3, 64'h5008, 64'h0, 0, 5'd11, 0, 3, 64'hDEAD_BEEF_0BAD_F00D, 0, 1);
      do_access(0, 2'd3, 64'h6000, 64'h0, 0, 5'd12, 0, TMO, 64'h0, 0, 0);

      rdata_en_ex2 = 1'b1; rlen_ex2 = 2'd2; mem_addr_ex2 = 64'h3004; rd_ex2 = 5'd3;
      @(negedge clk);
      rdata_en_ex2 = 1'b0;
      #1 chk("pre_rst_valid", bus_req_valid, 1);
      rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", bus_req_valid, 0);
      chk("mid_rst_hold", mem_hold, 0);
      chk("mid_rst_addr", bus_req_addr, 0);
      chk("mid_rst_wstrb", {56'h0, bus_req_wstrb}, 0);
      chk("mid_rst_ldata", load_data, 0);
      chk("mid_rst_rd", {59'h0, load_rd}, 0);
      chk("mid_rst_fault", access_fault_exc, 0);
      @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         bit st, uns, err, fl;
         logic [1:0] sz;
         logic [63:0] a, wd, rdat;
         int rdy, rsp;
         st  = 1'($urandom % 2);
         sz  = 2'($urandom % 4);
         a   = {$urandom, $urandom};
         if ($urandom % 4 != 0) a = a & ~((64'd1 << sz) - 64'd1);
         wd   = {$urandom, $urandom};
         rdat = {$urandom, $urandom};
         uns  = 1'($urandom % 2);
         rdy  = int'($urandom % 4);
         rsp  = int'($urandom % 4);
         err  = ($urandom % 8 == 0);
         fl   = (rsp > 0) && ($urandom % 6 == 0);
         do_access(st, sz, a, wd, uns, 5'($urandom % 32), rdy, rsp, rdat, err, fl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
